// File: rtl/irq_pkg.sv
// Shared interrupt definitions: source bit map, MMIO offsets and byte-enable helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irq_pkg;

    typedef enum logic [3:0] {
        VBLANK  = 4'd0,
        HBLANK  = 4'd1,
        VCOUNT  = 4'd2,
        TIMER0  = 4'd3,
        TIMER1  = 4'd4,
        TIMER2  = 4'd5,
        TIMER3  = 4'd6,
        SERIAL  = 4'd7,
        DMA0    = 4'd8,
        DMA1    = 4'd9,
        DMA2    = 4'd10,
        DMA3    = 4'd11,
        KEYPAD  = 4'd12,
        GAMEPAK = 4'd13
    } irq_src_e;

    localparam int          IRQ_NUM_SRC = 14;
    localparam logic [11:0] IE_IF_ADDR  = 12'h200;
    localparam logic [11:0] IME_ADDR    = 12'h208;

    // Expands two byte enables into a 16-bit bit mask.
    function automatic logic [15:0] be_mask16(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/irq_delay_line.sv
// 1-bit shift register of DEPTH stages with asynchronous clear.
// Latency: DEPTH cycles from d_i to q_o.
// Backpressure: none, shifts every cycle.
module irq_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    if (DEPTH == 1) begin : g_single
        assign stage_d = d_i;
    end else begin : g_shift
        assign stage_d = {stage_q[DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detects sources into IF, masks by IE/IME, drives delayed cpu_irq.
// Latency: IF set one clock after a source edge; cpu_irq follows pending by IRQ_DELAY clocks; halt_wake by 1.
// Backpressure: none; MMIO writes are single-cycle strobes that always complete.
import irq_pkg::*;

module irq_controller #(
    parameter int NUM_SRC   = IRQ_NUM_SRC,
    parameter int IRQ_DELAY = 3
) (
    input  logic               clock_16,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               wr_en,
    input  logic [11:0]        wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_be,
    output logic [15:0]        IE_out,
    output logic [15:0]        IF_out,
    output logic               IME_out,
    output logic               cpu_irq,
    output logic               halt_wake
);

    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    logic [NUM_SRC-1:0] src_prev_q;
    logic [15:0]        ie_q, ie_d;
    logic [15:0]        if_q, if_d;
    logic               ime_q, ime_d;
    logic               halt_wake_q;

    logic               ie_if_hit;
    logic               ime_hit;
    logic [15:0]        ie_wmask;
    logic [15:0]        if_clr;
    logic [15:0]        if_set;
    logic               pending;

    always_comb begin
        ie_if_hit = wr_en && (wr_addr == IE_IF_ADDR);
        ime_hit   = wr_en && (wr_addr == IME_ADDR);

        ie_wmask  = ie_if_hit ? be_mask16(wr_be[1:0]) : 16'h0000;
        ie_d      = ((ie_q & ~ie_wmask) | (wr_data[15:0] & ie_wmask)) & SRC_MASK;

        // A fresh edge overrides a same-cycle W1C so no request is lost.
        if_clr    = ie_if_hit ? (wr_data[31:16] & be_mask16(wr_be[3:2])) : 16'h0000;
        if_set    = 16'(irq_src & ~src_prev_q);
        if_d      = ((if_q & ~if_clr) | if_set) & SRC_MASK;

        ime_d     = (ime_hit && wr_be[0]) ? wr_data[0] : ime_q;

        pending   = ime_q & (|(ie_q & if_q));
    end

    // src_prev resets high so a line already asserted at reset release is not seen as an edge.
    always_ff @(posedge clock_16 or negedge reset_n) begin
        if (!reset_n) begin
            src_prev_q  <= '1;
            ie_q        <= 16'h0000;
            if_q        <= 16'h0000;
            ime_q       <= 1'b0;
            halt_wake_q <= 1'b0;
        end else begin
            src_prev_q  <= irq_src;
            ie_q        <= ie_d;
            if_q        <= if_d;
            ime_q       <= ime_d;
            halt_wake_q <= |(ie_q & if_q);
        end
    end

    irq_delay_line #(
        .DEPTH (IRQ_DELAY)
    ) u_irq_delay (
        .clk_i  (clock_16),
        .rst_ni (reset_n),
        .d_i    (pending),
        .q_o    (cpu_irq)
    );

    assign IE_out    = ie_q;
    assign IF_out    = if_q;
    assign IME_out   = ime_q;
    assign halt_wake = halt_wake_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int NUM_SRC   = 14;
    localparam int IRQ_DELAY = 3;

    logic               clock_16 = 1'b0;
    logic               reset_n;
    logic [NUM_SRC-1:0] irq_src;
    logic               wr_en;
    logic [11:0]        wr_addr;
    logic [31:0]        wr_data;
    logic [3:0]         wr_be;
    logic [15:0]        IE_out;
    logic [15:0]        IF_out;
    logic               IME_out;
    logic               cpu_irq;
    logic               halt_wake;

    int n_total = 0;
    int n_bad   = 0;

    irq_controller #(
        .NUM_SRC   (NUM_SRC),
        .IRQ_DELAY (IRQ_DELAY)
    ) dut (
        .clock_16  (clock_16),
        .reset_n   (reset_n),
        .irq_src   (irq_src),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .IE_out    (IE_out),
        .IF_out    (IF_out),
        .IME_out   (IME_out),
        .cpu_irq   (cpu_irq),
        .halt_wake (halt_wake)
    );

    always #5 clock_16 = ~clock_16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock_16);
        #1;
    endtask

    task automatic mmio_wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
        tick();
        wr_en   = 1'b0;
        wr_data = 32'h0;
        wr_be   = 4'h0;
    endtask

    initial begin
        reset_n = 1'b0;
        irq_src = '0;
        irq_src[TIMER0] = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 12'h000;
        wr_data = 32'h0;
        wr_be   = 4'h0;
        repeat (3) tick();

        check("rst_ie",   32'(IE_out),    32'h0);
        check("rst_if",   32'(IF_out),    32'h0);
        check("rst_ime",  32'(IME_out),   32'h0);
        check("rst_irq",  32'(cpu_irq),   32'h0);
        check("rst_halt", 32'(halt_wake), 32'h0);

        // 1: source held high through reset release must not set IF.
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("held_if",  32'(IF_out),  32'h0);
            check("held_irq", 32'(cpu_irq), 32'h0);
        end
        irq_src = '0;
        tick();

        // 2: IE=bit3, IME=1, one-cycle pulse on timer0.
        mmio_wr(IE_IF_ADDR, 32'h0000_0008, 4'b0011);
        mmio_wr(IME_ADDR,   32'h0000_0001, 4'b0001);
        check("ie_wr",  32'(IE_out),  32'h0008);
        check("ime_wr", 32'(IME_out), 32'h1);
        irq_src[3] = 1'b1;
        tick();
        irq_src = '0;
        check("pulse_if",  32'(IF_out),  32'h0008);
        check("pulse_irq0", 32'(cpu_irq), 32'h0);
        for (int i = 1; i <= IRQ_DELAY; i++) begin
            tick();
            check("rise_irq", 32'(cpu_irq), (i == IRQ_DELAY) ? 32'h1 : 32'h0);
        end
        check("rise_halt", 32'(halt_wake), 32'h1);
        repeat (4) tick();
        check("level_irq", 32'(cpu_irq), 32'h1);

        // Write to an unmapped offset changes nothing.
        mmio_wr(12'h204, 32'hFFFF_FFFF, 4'hF);
        check("bad_addr_ie",  32'(IE_out),  32'h0008);
        check("bad_addr_if",  32'(IF_out),  32'h0008);
        check("bad_addr_ime", 32'(IME_out), 32'h1);

        // 3: W1C of bit 3, cpu_irq falls IRQ_DELAY cycles after the write edge.
        mmio_wr(IE_IF_ADDR, 32'h0008_0000, 4'b1100);
        check("w1c_if",   32'(IF_out),  32'h0);
        check("w1c_ie",   32'(IE_out),  32'h0008);
        check("w1c_irq0", 32'(cpu_irq), 32'h1);
        for (int i = 1; i <= IRQ_DELAY; i++) begin
            tick();
            check("fall_irq", 32'(cpu_irq), (i == IRQ_DELAY) ? 32'h0 : 32'h1);
        end
        check("fall_halt", 32'(halt_wake), 32'h0);

        // 4: set and clear of bit 4 in the same cycle, set wins.
        irq_src[4] = 1'b1;
        mmio_wr(IE_IF_ADDR, 32'h0010_0000, 4'b1100);
        check("set_wins_if", 32'(IF_out), 32'h0010);
        // Clearing while the line stays high must not re-set the bit.
        mmio_wr(IE_IF_ADDR, 32'h0010_0000, 4'b1100);
        check("held_clr_if", 32'(IF_out), 32'h0);
        repeat (3) tick();
        check("held_noreset_if", 32'(IF_out), 32'h0);
        irq_src = '0;
        tick();

        // 5: IME=0, IE=bit4: halt_wake asserts, cpu_irq stays low.
        mmio_wr(IME_ADDR,   32'h0000_0000, 4'b0001);
        mmio_wr(IE_IF_ADDR, 32'h0000_0010, 4'b0011);
        check("ime_off", 32'(IME_out), 32'h0);
        check("ie_b4",   32'(IE_out),  32'h0010);
        irq_src[4] = 1'b1;
        tick();
        irq_src = '0;
        check("wake_if",    32'(IF_out),    32'h0010);
        check("wake_halt1", 32'(halt_wake), 32'h0);
        tick();
        check("wake_halt2", 32'(halt_wake), 32'h1);
        for (int i = 0; i < IRQ_DELAY + 2; i++) begin
            tick();
            check("ime_off_irq", 32'(cpu_irq), 32'h0);
        end

        // 6: all sources at once, then byte-0-only write leaves IF intact.
        irq_src = 14'h3FFF;
        tick();
        irq_src = '0;
        check("multi_if", 32'(IF_out), 32'h3FFF);
        mmio_wr(IE_IF_ADDR, 32'hFFFF_FFFF, 4'b0001);
        check("be0_ie", 32'(IE_out), 32'h00FF);
        check("be0_if", 32'(IF_out), 32'h3FFF);
        // Full write: IE bits above NUM_SRC stay 0, IF fully cleared.
        mmio_wr(IE_IF_ADDR, 32'hFFFF_FFFF, 4'b1111);
        check("full_ie", 32'(IE_out), 32'h3FFF);
        check("full_if", 32'(IF_out), 32'h0);
        mmio_wr(IME_ADDR, 32'hFFFF_FFFE, 4'b1111);
        check("ime_bit0_only", 32'(IME_out), 32'h0);
        mmio_wr(IME_ADDR, 32'h0000_0001, 4'b1110);
        check("ime_be_off", 32'(IME_out), 32'h0);
        mmio_wr(IME_ADDR, 32'hFFFF_FFFF, 4'b0001);
        check("ime_set", 32'(IME_out), 32'h1);

        // Reset while the delay line is full clears everything asynchronously.
        irq_src[VBLANK] = 1'b1;
        tick();
        irq_src = '0;
        check("pre_rst_if", 32'(IF_out), 32'h0001);
        repeat (IRQ_DELAY) tick();
        check("pre_rst_irq", 32'(cpu_irq), 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_rst_irq",  32'(cpu_irq),   32'h0);
        check("async_rst_halt", 32'(halt_wake), 32'h0);
        check("async_rst_if",   32'(IF_out),    32'h0);
        check("async_rst_ie",   32'(IE_out),    32'h0);
        check("async_rst_ime",  32'(IME_out),   32'h0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
